// File: rtl/alu_ctrl_issue_pkg.sv
// Shared constants and types for the ALU control encoder and its issue stage.
// Used by both the pipelined issue path and the single-cycle control path.
package alu_ctrl_issue_pkg;

  localparam logic [1:0] OPC_MEM = 2'b00;
  localparam logic [1:0] OPC_BR  = 2'b01;
  localparam logic [1:0] OPC_R   = 2'b10;
  localparam logic [1:0] OPC_I   = 2'b11;

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_SUB  = 4'b0011;
  localparam logic [3:0] F_SLT  = 4'b0100;
  localparam logic [3:0] F_XOR  = 4'b0101;
  localparam logic [3:0] F_NOR  = 4'b0110;
  localparam logic [3:0] F_NAND = 4'b0111;

  localparam logic [2:0] SEL_AND = 3'b000;
  localparam logic [2:0] SEL_OR  = 3'b001;
  localparam logic [2:0] SEL_ADD = 3'b010;
  localparam logic [2:0] SEL_SLT = 3'b011;
  localparam logic [2:0] SEL_XOR = 3'b101;

  typedef struct packed {
    logic [2:0] sel;
    logic       ainvert;
    logic       bnegate;
  } ctrl_t;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_ONE,
    OCC_FULL
  } occ_e;

  function automatic ctrl_t mk_ctrl(input logic [2:0] sel, input logic ainv, input logic bneg);
    ctrl_t c;
    c.sel     = sel;
    c.ainvert = ainv;
    c.bnegate = bneg;
    return c;
  endfunction

  localparam ctrl_t CTRL_ADD = '{sel: SEL_ADD, ainvert: 1'b0, bnegate: 1'b0};
  localparam ctrl_t CTRL_SUB = '{sel: SEL_ADD, ainvert: 1'b0, bnegate: 1'b1};

endpackage

// File: rtl/alu_ctrl_issue_encode.sv
// Combinational (op class, funct) -> ALU control word plus illegal flag.
// Illegal encodings fall back to ADD so the result mux only sees legal selects.
module alu_ctrl_encode
  import alu_ctrl_issue_pkg::*;
#(
  parameter int unsigned FUNCT_W = 4
) (
  input  logic [1:0]         alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output ctrl_t              ctrl_o,
  output logic               illegal_o
);

  ctrl_t r_ctrl;
  logic  r_ok;
  logic  i_ok;

  always_comb begin
    r_ctrl = CTRL_ADD;
    r_ok   = 1'b1;
    i_ok   = 1'b1;
    case (funct_i)
      FUNCT_W'(F_AND):  r_ctrl = mk_ctrl(SEL_AND, 1'b0, 1'b0);
      FUNCT_W'(F_OR):   r_ctrl = mk_ctrl(SEL_OR,  1'b0, 1'b0);
      FUNCT_W'(F_ADD):  r_ctrl = mk_ctrl(SEL_ADD, 1'b0, 1'b0);
      FUNCT_W'(F_SUB):  r_ctrl = mk_ctrl(SEL_ADD, 1'b0, 1'b1);
      FUNCT_W'(F_SLT):  r_ctrl = mk_ctrl(SEL_SLT, 1'b0, 1'b1);
      FUNCT_W'(F_XOR):  r_ctrl = mk_ctrl(SEL_XOR, 1'b0, 1'b0);
      FUNCT_W'(F_NOR):  r_ctrl = mk_ctrl(SEL_AND, 1'b1, 1'b1);
      FUNCT_W'(F_NAND): r_ctrl = mk_ctrl(SEL_OR,  1'b1, 1'b1);
      default:          r_ok   = 1'b0;
    endcase
    // Immediate class only supports the subset without a register-only form
    case (funct_i)
      FUNCT_W'(F_AND), FUNCT_W'(F_OR), FUNCT_W'(F_ADD),
      FUNCT_W'(F_SLT), FUNCT_W'(F_XOR): i_ok = 1'b1;
      default:                          i_ok = 1'b0;
    endcase
  end

  always_comb begin
    ctrl_o    = CTRL_ADD;
    illegal_o = 1'b0;
    case (alu_op_i)
      OPC_MEM: ctrl_o = CTRL_ADD;
      OPC_BR:  ctrl_o = CTRL_SUB;
      OPC_R: begin
        ctrl_o    = r_ok ? r_ctrl : CTRL_ADD;
        illegal_o = ~r_ok;
      end
      OPC_I: begin
        ctrl_o    = i_ok ? r_ctrl : CTRL_ADD;
        illegal_o = ~i_ok;
      end
      default: ctrl_o = CTRL_ADD;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// ALU control issue stage: encodes decoded op fields and issues them through
// a 2-entry skid buffer with registered ready/valid, sticky illegal flag and issue counter.
module alu_ctrl_issue
  import alu_ctrl_issue_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned FUNCT_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [1:0]         alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [2:0]         sel_o,
  output logic               ainvert_o,
  output logic               bnegate_o,
  output logic               illegal_o,
  output logic [CNT_W-1:0]   issue_cnt_o
);

  occ_e             state_q, state_d;
  ctrl_t            head_q, head_d;
  ctrl_t            skid_q, skid_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic             ill_q, ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  ctrl_t enc_ctrl;
  logic  enc_illegal;
  logic  in_xfer;
  logic  out_xfer;

  alu_ctrl_encode #(
    .FUNCT_W (FUNCT_W)
  ) u_encode (
    .alu_op_i  (alu_op_i),
    .funct_i   (funct_i),
    .ctrl_o    (enc_ctrl),
    .illegal_o (enc_illegal)
  );

  // Ready is held low for the whole reset window, not just after the first edge
  assign in_ready_o  = rdy_q & ~rst_i;
  assign out_valid_o = vld_q;
  assign sel_o       = head_q.sel;
  assign ainvert_o   = head_q.ainvert;
  assign bnegate_o   = head_q.bnegate;
  assign illegal_o   = ill_q;
  assign issue_cnt_o = cnt_q;

  assign in_xfer  = in_valid_i & in_ready_o;
  assign out_xfer = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    ill_d   = ill_q | (in_xfer & enc_illegal);
    cnt_d   = out_xfer ? cnt_q + CNT_W'(1) : cnt_q;
    case (state_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          head_d  = enc_ctrl;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = enc_ctrl;
        end else if (in_xfer) begin
          skid_d  = enc_ctrl;
          state_d = OCC_FULL;
        end else if (out_xfer) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (out_xfer) begin
          head_d  = skid_q;
          state_d = OCC_ONE;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
    rdy_d = (state_d != OCC_FULL);
    vld_d = (state_d != OCC_EMPTY);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OCC_EMPTY;
      head_q  <= CTRL_ADD;
      skid_q  <= CTRL_ADD;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      ill_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      ill_q   <= ill_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/alu_ctrl_issue.md
Name: alu_ctrl_issue

Overview:
- Control-side counterpart of the ALU result select mux.
- Accepts decoded instruction fields (ALU op class plus funct) over a valid/ready handshake.
- Encodes each one into the 3-bit ALU result select plus the operand-invert controls, and issues them downstream through a 2-entry skid buffer.
- Guarantees the ALU mux only ever sees its five legal select codes. Also flags illegal funct codes and counts issued operations.

Parameters:
- CNT_W, 16, width of issued-operation counter.
- FUNCT_W, 4, width of funct field.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream holds valid op fields.
- in_ready  output  1  block can accept this cycle.
- alu_op  input  2  op class: 00 load/store, 01 branch, 10 R-type, 11 immediate.
- funct  input  FUNCT_W  operation code (used for classes 10/11).
- out_valid  output  1  issued control word valid.
- out_ready  input  1  ALU/datapath consumes this cycle.
- sel  output  3  ALU result select: 000 AND, 001 OR, 010 ADD, 011 SLT, 101 XOR.
- ainvert  output  1  invert operand A.
- bnegate  output  1  invert operand B and carry-in 1.
- illegal  output  1  sticky: an illegal funct was accepted.
- issue_cnt  output  CNT_W  number of control words consumed downstream.

Behaviour:
- Transfers: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- Encoding (combinational, applied at input transfer):
  - Class 00 -> ADD: sel 010, ainv 0, bneg 0.
  - Class 01 -> SUB: sel 010, ainv 0, bneg 1.
  - Class 10 funct:
    - 0000 AND (000,0,0)
    - 0001 OR (001,0,0)
    - 0010 ADD (010,0,0)
    - 0011 SUB (010,0,1)
    - 0100 SLT (011,0,1)
    - 0101 XOR (101,0,0)
    - 0110 NOR (000,1,1)
    - 0111 NAND (001,1,1)
    - all others illegal.
  - Class 11: only funct 0000, 0001, 0010, 0100, 0101 are legal, encoded as in class 10. All others are illegal.
  - Illegal input: encoded as ADD (010,0,0), still issued, and sets `illegal`.
  - sel values 100, 110 and 111 are never driven, in any state including reset.
- Skid buffer states (occupancy):
  - EMPTY: in_ready=1, out_valid=0.
  - ONE: in_ready=1, out_valid=1.
  - FULL: in_ready=0, out_valid=1.
  - EMPTY -> ONE on input transfer.
  - ONE -> FULL on input transfer without output transfer.
  - ONE -> EMPTY on output transfer without input transfer.
  - ONE stays ONE on simultaneous input and output transfer.
  - FULL -> ONE on output transfer.
- Output ordering: the head entry drives the outputs and is strictly FIFO.
- Latency: input accepted in cycle N appears on outputs in cycle N+1 when the buffer was empty.
- Registering: in_ready is a registered function of occupancy only and never depends combinationally on out_ready. Outputs are registered.
- Throughput: one op per cycle in steady state with out_ready held high.
- Output stability: while out_valid=1 and out_ready=0, sel, ainvert and bnegate hold stable.
- illegal: set on the input transfer of an illegal op (visible next cycle), cleared only by Reset.
- issue_cnt: increments by 1 per output transfer and wraps from all-ones to 0.
- Reset:
  - Takes effect at the next rising edge, mid-stream included, and discards buffered entries.
  - Reset values: out_valid=0, in_ready=1 from the cycle after Reset, sel=010, ainvert=0, bnegate=0, illegal=0, issue_cnt=0.
  - in_ready=0 while Reset is high.

Decomposition:
- Shared package holds:
  - op-class constants (OPC_MEM, OPC_BR, OPC_R, OPC_I);
  - funct constants (F_AND..F_NAND);
  - select constants (SEL_AND=000, SEL_OR=001, SEL_ADD=010, SEL_SLT=011, SEL_XOR=101);
  - a 5-bit control-word type {sel, ainvert, bnegate}.
- One sub-module, alu_ctrl_encode: purely combinational (alu_op, funct) -> control word + illegal bit. It is reused by the single-cycle control path.

Test Plan:
- Reset, then R-type funct 0000..0111 back-to-back with out_ready=1 -> outputs in order (000,0,0) (001,0,0) (010,0,0) (010,0,1) (011,0,1) (101,0,0) (000,1,1) (001,1,1), one per cycle from cycle 1; issue_cnt=8; illegal=0.
- Class 00, then class 01, then class 11 funct 0011 -> (010,0,0), (010,0,1), (010,0,0) with illegal rising the cycle after the third op is accepted and staying 1.
- out_ready=0, push 3 ops -> first two accepted, in_ready=0 after the second, head holds stable; raise out_ready -> third accepted, order preserved, no loss or duplication.
- Random in_valid/out_ready for 10k cycles against a reference queue model -> sel never in {100,110,111}; count of output transfers equals issue_cnt mod 2^16.
- Preload issue_cnt near wrap (0xFFFE), 3 transfers -> 0xFFFF, 0x0000, 0x0001.
- Assert Reset while buffer FULL -> next cycle out_valid=0, illegal=0, issue_cnt=0, sel=010; in_ready=1 the cycle after Reset drops.
